// File: rtl/accum_pkg.sv
// Shared FSM encoding, default sizes and a counter-width helper for the
// debounced accumulator.
package accum_pkg;

  localparam int W_DEF   = 8;
  localparam int DEB_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CAPTURE  = 2'd1,
    S_ADD      = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: two-flop synchronizer, DEB-cycle debounce
// and a one-cycle press pulse; no pulse until a release is seen after reset.
module key_debounce
  import accum_pkg::*;
#(
  parameter int DEB = DEB_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_evt_o
);

  localparam int             CW      = cnt_bits(DEB);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB - 1);

  logic          sync1_q, sync2_q, stable_q, prev_q, armed_q;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_d, armed_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
    // vld_q[1] marks sync2_q as a real sample rather than its reset value
    armed_d = armed_q | (vld_q[1] & sync2_q & stable_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
      armed_q  <= 1'b0;
      vld_q    <= 2'b00;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      armed_q  <= armed_d;
      vld_q    <= {vld_q[0], 1'b1};
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_o   = ~stable_q;
  assign press_evt_o = armed_q & prev_q & ~stable_q;

endmodule

// File: rtl/accum_seq.sv
// Push-button accumulator: KEY[1] adds SW into a W-bit sum with sticky
// overflow, KEY[2] clears; LEDR shows sum, overflow and busy, all registered.
module accum_seq
  import accum_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int DEB = DEB_DEF
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  state_t         state_q, state_d;
  logic           busy_q;
  logic [W-1:0]   sum_q, sum_d, opnd_q, opnd_d;
  logic           ovf_q, ovf_d;
  logic [W:0]     add_full;
  logic           add_evt, clr_evt, add_held;
  logic           unused_clr_held;
  logic           unused_inputs;

  assign unused_inputs = ^{KEY[3], KEY[0], SW};

  key_debounce #(.DEB(DEB)) u_add_key (
    .clk_i       (CLOCK_50),
    .rst_ni      (Resetn),
    .key_ni      (KEY[1]),
    .pressed_o   (add_held),
    .press_evt_o (add_evt)
  );

  key_debounce #(.DEB(DEB)) u_clr_key (
    .clk_i       (CLOCK_50),
    .rst_ni      (Resetn),
    .key_ni      (KEY[2]),
    .pressed_o   (unused_clr_held),
    .press_evt_o (clr_evt)
  );

  assign add_full = {1'b0, sum_q} + {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    opnd_d  = opnd_q;
    ovf_d   = ovf_q;
    // clear outranks everything, including an add already in flight
    if (clr_evt) begin
      state_d = S_IDLE;
      sum_d   = '0;
      opnd_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:     if (add_evt) state_d = S_CAPTURE;
        S_CAPTURE: begin
          opnd_d  = SW[W-1:0];
          state_d = S_ADD;
        end
        S_ADD: begin
          sum_d   = add_full[W-1:0];
          ovf_d   = ovf_q | add_full[W];
          state_d = S_WAIT_REL;
        end
        S_WAIT_REL: if (!add_held) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sum_q  <= '0;
      opnd_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      opnd_q <= opnd_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    LEDR         = '0;
    LEDR[W-1:0]  = sum_q;
    LEDR[8]      = ovf_q;
    LEDR[9]      = busy_q;
  end

endmodule

// File: tb/tb_accum_seq.sv
// Randomized and directed bench for accum_seq against a cycle-indexed
// transaction model of the key conditioning and accumulate/clear behaviour.
module tb_accum_seq;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       Resetn;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int n_chk  = 0;
  int n_fail = 0;

  accum_seq #(.W(8), .DEB(DEB)) dut (
    .CLOCK_50 (clk),
    .Resetn   (Resetn),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR)
  );

  always #5 clk = ~clk;

  // reference model state; index 0 = add key, 1 = clear key
  int       cyc = 0;
  bit       m_h1 [2];
  bit       m_h2 [2];
  int       m_nsamp [2];
  bit       m_acc [2];
  int       m_run [2];
  bit       m_armed [2];
  bit       m_evt [2];
  bit       m_busy;
  int       m_tcap, m_tadd;
  bit [7:0] m_sum, m_opnd;
  bit       m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_h1[k] = 1'b1; m_h2[k] = 1'b1; m_nsamp[k] = 0;
      m_acc[k] = 1'b1; m_run[k] = 0; m_armed[k] = 1'b0; m_evt[k] = 1'b0;
    end
    m_busy = 1'b0; m_tcap = -1; m_tadd = -1;
    m_sum = '0; m_opnd = '0; m_ovf = 1'b0;
  endtask

  // one rising edge; raw/sw are the values present just before it
  task automatic model_edge(input bit [1:0] raw, input bit [7:0] sw);
    logic [8:0] t;
    bit s, pre;
    int e;
    cyc++;
    e = cyc;
    if (m_evt[1]) begin
      m_sum = '0; m_ovf = 1'b0; m_opnd = '0;
      m_busy = 1'b0; m_tcap = -1; m_tadd = -1;
    end else if (m_busy) begin
      if (e == m_tcap) m_opnd = sw;
      else if (e == m_tadd) begin
        t = {1'b0, m_sum} + {1'b0, m_opnd};
        m_sum = t[7:0];
        m_ovf = m_ovf | t[8];
      end else if (e > m_tadd && m_acc[0]) m_busy = 1'b0;
    end else if (m_evt[0]) begin
      m_busy = 1'b1; m_tcap = e + 1; m_tadd = e + 2;
    end
    for (int k = 0; k < 2; k++) begin
      s   = (m_nsamp[k] >= 2) ? m_h2[k] : 1'b1;
      pre = m_acc[k];
      m_armed[k] = m_armed[k] | ((m_nsamp[k] >= 2) && s && pre);
      if (s != pre) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin m_acc[k] = s; m_run[k] = 0; end
      end else m_run[k] = 0;
      m_evt[k] = m_armed[k] && pre && !m_acc[k];
      m_h2[k] = m_h1[k];
      m_h1[k] = raw[k];
      if (m_nsamp[k] < 2) m_nsamp[k]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (Resetn) model_edge({KEY[2], KEY[1]}, SW[7:0]);
    #1;
    check_eq("ledr", 32'(LEDR), 32'({m_busy, m_ovf, m_sum}));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int kb, input int nb, input int hold, input int rel, input bit rnd_sw);
    repeat (nb) begin
      KEY[kb] = 1'b0; ticks(3);
      KEY[kb] = 1'b1; ticks(1);
    end
    KEY[kb] = 1'b0;
    repeat (hold) begin
      if (rnd_sw && $urandom_range(0, 3) == 0) SW = 10'($urandom);
      tick();
    end
    KEY[kb] = 1'b1;
    ticks(rel);
  endtask

  task automatic do_add(input bit [7:0] v);
    SW = {2'b00, v};
    press(1, 0, 12, 12, 1'b0);
  endtask

  task automatic do_clr();
    press(2, 0, 12, 12, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    Resetn = 1'b0; KEY = 4'hF; SW = '0;
    model_reset();
    ticks(3);
    check_eq("reset_ledr", 32'(LEDR), 32'h0);
    Resetn = 1'b1;
    ticks(5);

    // single clean press: sum appears two cycles after the event cycle
    SW = 10'h005; KEY[1] = 1'b0;
    ticks(8);
    check_eq("add_not_early", 32'(LEDR[7:0]), 32'h00);
    ticks(1);
    check_eq("add_latency", 32'(LEDR[7:0]), 32'h05);
    ticks(3);
    check_eq("busy_while_held", 32'(LEDR[9]), 32'h1);
    KEY[1] = 1'b1;
    ticks(12);
    check_eq("after_release", 32'(LEDR), 32'h005);

    // wraparound with sticky overflow
    do_clr();
    do_add(8'hF0);
    do_add(8'h20);
    check_eq("wrap_overflow", 32'(LEDR), 32'h110);
    do_add(8'h01);
    check_eq("overflow_sticky", 32'(LEDR), 32'h111);

    // bouncing press gives exactly one add
    do_clr();
    SW = 10'h003;
    press(1, 3, 10, 12, 1'b0);
    check_eq("bounce_one_add", 32'(LEDR), 32'h003);

    // simultaneous add and clear: clear wins
    do_clr();
    do_add(8'h33);
    check_eq("pre_clear_sum", 32'(LEDR), 32'h033);
    KEY[2:1] = 2'b00;
    ticks(12);
    KEY[2:1] = 2'b11;
    ticks(12);
    check_eq("clear_beats_add", 32'(LEDR), 32'h000);

    // operand latched in CAPTURE; later SW changes ignored
    do_clr();
    SW = 10'h007; KEY[1] = 1'b0;
    ticks(8);
    SW = 10'h009;
    ticks(6);
    KEY[1] = 1'b1;
    ticks(12);
    check_eq("operand_latched", 32'(LEDR), 32'h007);

    // asynchronous reset during ADD while the add key stays held
    do_clr();
    SW = 10'h011; KEY[1] = 1'b0;
    ticks(8);
    #2 Resetn = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset", 32'(LEDR), 32'h000);
    #1 Resetn = 1'b1;
    ticks(30);
    check_eq("held_through_reset", 32'(LEDR), 32'h000);
    KEY[1] = 1'b1;
    ticks(15);
    press(1, 0, 12, 12, 1'b0);
    check_eq("readd_after_reset", 32'(LEDR[7:0]), 32'h11);

    // random mix of adds, clears, bounces, short presses and SW churn
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      SW = 10'($urandom);
      if (r < 7) begin
        press(1, $urandom_range(0, 1) * 2, $urandom_range(1, 14), $urandom_range(1, 14), 1'b1);
      end else if (r < 9) begin
        press(2, 0, $urandom_range(1, 14), $urandom_range(1, 14), 1'b1);
      end else begin
        KEY[2:1] = 2'b00;
        ticks($urandom_range(1, 14));
        KEY[2:1] = 2'b11;
        ticks($urandom_range(1, 14));
      end
    end
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand and sum width.
REQ-002 SHALL have parameter DEB, default 4, the number of consecutive stable clock cycles a key level needs before it is accepted; boards use 500000.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port KEY  input  4  raw pushbuttons, active-low; KEY[1]=add, KEY[2]=clear, KEY[0] and KEY[3] unused.
REQ-006 SHALL have port SW  input  10  switches; SW[W-1:0]=operand, rest unused.
REQ-007 SHALL have port LEDR  output  10  LEDR[W-1:0]=sum, LEDR[8]=overflow, LEDR[9]=busy.

Function
REQ-010 SHALL pass KEY[1] and KEY[2] through a two-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized key: the accepted level changes only after the raw level differs from it for DEB consecutive cycles; any bounce restarts the count.
REQ-012 SHALL generate add_evt or clr_evt for exactly one cycle when the matching debounced key goes from released to pressed.
REQ-013 SHALL implement FSM states IDLE, CAPTURE, ADD and WAIT_REL.
REQ-014 SHALL move IDLE->CAPTURE on add_evt, CAPTURE->ADD unconditionally, ADD->WAIT_REL unconditionally, and WAIT_REL->IDLE when the debounced add key is released.
REQ-015 SHALL latch SW[W-1:0] into the operand register in CAPTURE; SW changes after that cycle do not affect the add.
REQ-016 SHALL in ADD set sum to (sum + operand) mod 2^W, and set overflow when the carry out is 1.
REQ-017 SHALL keep overflow sticky until clear or reset.
REQ-018 SHALL make the new sum visible on LEDR 2 cycles after the add_evt cycle.
REQ-019 SHALL perform exactly one add per debounced press; holding the key gives no repeats.
REQ-020 SHALL on clr_evt in any state zero sum, overflow and operand on the next edge and force the FSM to IDLE.
REQ-021 SHALL give clear priority when clr_evt coincides with add_evt or with the ADD state: the add is discarded.
REQ-022 SHALL ignore add_evt outside IDLE.
REQ-023 SHALL drive LEDR[9] high exactly when state != IDLE.
REQ-024 SHALL drive LEDR from registers only, with no combinational path from KEY or SW to LEDR.

Reset
REQ-030 SHALL on Resetn=0, immediately and independent of the clock: state=IDLE, sum=0, operand=0, overflow=0, LEDR=0, synchronizer and debounce flops at released level, debounce counters 0.
REQ-031 SHALL generate no add_evt or clr_evt when Resetn is released while a key is held; the key must be released and pressed again.

Structure
REQ-040 SHALL place the FSM state encoding and the default values of W and DEB in shared package accum_pkg.
REQ-041 SHALL implement synchronizer, debounce counter and press-edge detect as sub-module key_debounce, parameterized by DEB, instanced twice.
REQ-042 SHALL keep the datapath (operand and sum registers, adder, overflow) in accum_seq, controlled only by the FSM.

Verification (DEB=4)
REQ-050 SHALL cover: SW=0x05, clean KEY[1] press -> LEDR[7:0]=0x05 2 cycles after add_evt, LEDR[9] high until debounced release.
REQ-051 SHALL cover: sum=0xF0, SW=0x20, add -> LEDR[7:0]=0x10, LEDR[8]=1; then SW=0x01, add -> 0x11, LEDR[8] still 1.
REQ-052 SHALL cover: KEY[1] bounces 3 cycles low/1 high x3, then steady low 10 cycles -> exactly one add.
REQ-053 SHALL cover: KEY[1] and KEY[2] pressed in the same cycle with sum=0x33 -> sum=0, overflow=0, state IDLE, no add.
REQ-054 SHALL cover: SW changed from 0x07 to 0x09 in the cycle after CAPTURE -> sum grows by 0x07.
REQ-055 SHALL cover: Resetn pulsed low mid-ADD while KEY[1] is held -> LEDR=0 at once; no add after Resetn rises until KEY[1] is released and pressed again.
